// File: rtl/mem_stage_wb_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface mem_stage_wb_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_wb.sv
// MEM stage: consumes EX/MEM, runs data-memory accesses over a req/ack bus with timeout,
// resolves branch/jump and registers the MEM/WB pipeline state.
module mem_stage_wb #(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [2:0]           M,
    input  logic [2:0]           WB,
    input  logic [31:0]          Add_result,
    input  logic                 zero,
    input  logic [31:0]          Alu_result,
    input  logic [31:0]          Dato2,
    input  logic [4:0]           Direccion,
    input  logic                 jump,
    input  logic [31:0]          jump_address,
    mem_stage_wb_if.master       bus,
    output logic                 stall,
    output logic                 pc_src,
    output logic [31:0]          pc_target,
    output logic                 mem_err,
    output logic                 valid_out,
    output logic [2:0]           WB_out,
    output logic [31:0]          Read_data_out,
    output logic [31:0]          Alu_result_out,
    output logic [4:0]           Direccion_out
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          memop;
    logic          ack_hit;
    logic          timeout_hit;

    assign memop       = in_valid & (M[1] | M[0]);
    assign ack_hit     = (state == ACCESS) & bus.mem_ack;
    assign timeout_hit = (state == ACCESS) & ~bus.mem_ack & (cnt == CNT_LAST);

    // Redirect only from IDLE so a held instruction can never redirect twice.
    assign pc_src    = in_valid & (state == IDLE) & (jump | (M[2] & zero));
    assign pc_target = jump ? jump_address : Add_result;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                stall = ~(ack_hit | timeout_hit);
                if (ack_hit | timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            cnt            <= '0;
            mem_err        <= 1'b0;
            valid_out      <= 1'b0;
            WB_out         <= '0;
            Read_data_out  <= '0;
            Alu_result_out <= '0;
            Direccion_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= M[0];
                        bus.mem_addr  <= {Alu_result[31:2], 2'b00};
                        bus.mem_wdata <= Dato2;
                        cnt           <= '0;
                        valid_out     <= 1'b0;
                        WB_out        <= '0;
                    end else begin
                        valid_out      <= in_valid;
                        WB_out         <= in_valid ? WB : 3'b000;
                        Read_data_out  <= '0;
                        Alu_result_out <= Alu_result;
                        Direccion_out  <= Direccion;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CW'(1);
                    if (ack_hit) begin
                        bus.mem_req    <= 1'b0;
                        valid_out      <= 1'b1;
                        WB_out         <= WB;
                        Read_data_out  <= bus.mem_we ? 32'h0 : bus.mem_rdata;
                        Alu_result_out <= Alu_result;
                        Direccion_out  <= Direccion;
                    end else if (timeout_hit) begin
                        // Aborted access still retires, but must not write the register file.
                        bus.mem_req    <= 1'b0;
                        mem_err        <= 1'b1;
                        valid_out      <= 1'b1;
                        WB_out         <= {WB[2:1], 1'b0};
                        Read_data_out  <= '0;
                        Alu_result_out <= Alu_result;
                        Direccion_out  <= Direccion;
                    end else begin
                        valid_out <= 1'b0;
                        WB_out    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb: stimulus pushes expected MEM/WB completions into a queue,
// a negedge monitor pops and compares every valid_out beat.
module tb_mem_stage_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  M;
    logic [2:0]  WB;
    logic [31:0] Add_result;
    logic        zero;
    logic [31:0] Alu_result;
    logic [31:0] Dato2;
    logic [4:0]  Direccion;
    logic        jump;
    logic [31:0] jump_address;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        mem_err;
    logic        valid_out;
    logic [2:0]  WB_out;
    logic [31:0] Read_data_out;
    logic [31:0] Alu_result_out;
    logic [4:0]  Direccion_out;

    mem_stage_wb_if bus ();

    mem_stage_wb #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .M              (M),
        .WB             (WB),
        .Add_result     (Add_result),
        .zero           (zero),
        .Alu_result     (Alu_result),
        .Dato2          (Dato2),
        .Direccion      (Direccion),
        .jump           (jump),
        .jump_address   (jump_address),
        .bus            (bus.master),
        .stall          (stall),
        .pc_src         (pc_src),
        .pc_target      (pc_target),
        .mem_err        (mem_err),
        .valid_out      (valid_out),
        .WB_out         (WB_out),
        .Read_data_out  (Read_data_out),
        .Alu_result_out (Alu_result_out),
        .Direccion_out  (Direccion_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dir;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every retired instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'(valid_out), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("WB_out", 32'(WB_out), 32'(e.wb));
                check("Read_data_out", Read_data_out, e.rd);
                check("Alu_result_out", Alu_result_out, e.alu);
                check("Direccion_out", 32'(Direccion_out), 32'(e.dir));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; M = 3'b000; WB = 3'b000; zero = 1'b0; jump = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic issue(input logic [2:0] m, input logic [2:0] wb, input logic [31:0] alu,
                         input logic [31:0] d2, input logic [4:0] dir);
        in_valid = 1'b1; M = m; WB = wb; Alu_result = alu; Dato2 = d2; Direccion = dir;
    endtask

    task automatic alu_op(input logic [2:0] wb, input logic [31:0] alu, input logic [4:0] dir);
        issue(3'b000, wb, alu, 32'h0, dir);
        exp_q.push_back('{wb: wb, rd: 32'h0, alu: alu, dir: dir});
        @(negedge clk);
        check("alu_stall", 32'(stall), 32'h0);
        step();
        clear_inputs();
    endtask

    // Memory op already presented in IDLE; ack on the (lat+1)-th ACCESS cycle.
    task automatic mem_op(input int lat, input logic [31:0] rdata, input logic [31:0] addr,
                          input logic we, input logic [31:0] wdata, output int stalls);
        stalls = 0;
        for (int c = 0; c <= lat + 1; c++) begin
            if (c == lat + 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end
            @(negedge clk);
            if (stall) stalls++;
            if (c == 1) begin
                check("mem_req", 32'(bus.mem_req), 32'h1);
                check("mem_addr", bus.mem_addr, addr);
                check("mem_we", 32'(bus.mem_we), 32'(we));
                if (we) check("mem_wdata", bus.mem_wdata, wdata);
            end
            step();
        end
        clear_inputs();
        check("mem_req_drop", 32'(bus.mem_req), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        clear_inputs();
        Add_result = '0; Alu_result = '0; Dato2 = '0; Direccion = '0;
        jump_address = '0; bus.mem_rdata = '0;
        #12;
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_mem_err", 32'(mem_err), 32'h0);
        check("rst_WB_out", 32'(WB_out), 32'h0);
        check("rst_Alu_result_out", Alu_result_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ALU op, single-cycle latency
        alu_op(3'b001, 32'h10, 5'd5);
        alu_op(3'b011, 32'hDEAD_BEEF, 5'd31);

        // Load with three wait cycles; address low bits dropped
        issue(3'b010, 3'b011, 32'h103, 32'h0, 5'd7);
        exp_q.push_back('{wb: 3'b011, rd: 32'hCAFE_F00D, alu: 32'h103, dir: 5'd7});
        mem_op(3, 32'hCAFE_F00D, 32'h100, 1'b0, 32'h0, n);
        check("load_stall_cycles", 32'(n), 32'd4);

        // Zero-wait store; load data must read back as 0
        issue(3'b001, 3'b000, 32'h20, 32'h55, 5'd0);
        exp_q.push_back('{wb: 3'b000, rd: 32'h0, alu: 32'h20, dir: 5'd0});
        mem_op(0, 32'h1234_5678, 32'h20, 1'b1, 32'h55, n);
        check("store_stall_cycles", 32'(n), 32'd1);

        // Read and write both set: write wins
        issue(3'b011, 3'b000, 32'h47, 32'hA5A5_0001, 5'd2);
        exp_q.push_back('{wb: 3'b000, rd: 32'h0, alu: 32'h47, dir: 5'd2});
        mem_op(1, 32'hFFFF_FFFF, 32'h44, 1'b1, 32'hA5A5_0001, n);

        // Branch / jump resolution
        issue(3'b100, 3'b000, 32'h0, 32'h0, 5'd0);
        zero = 1'b1; Add_result = 32'h40; jump_address = 32'h80;
        exp_q.push_back('{wb: 3'b000, rd: 32'h0, alu: 32'h0, dir: 5'd0});
        #1;
        check("branch_taken_pc_src", 32'(pc_src), 32'h1);
        check("branch_pc_target", pc_target, 32'h40);
        check("branch_stall", 32'(stall), 32'h0);
        step();
        zero = 1'b0;
        exp_q.push_back('{wb: 3'b000, rd: 32'h0, alu: 32'h0, dir: 5'd0});
        #1;
        check("branch_not_taken_pc_src", 32'(pc_src), 32'h0);
        step();
        M = 3'b000; jump = 1'b1;
        exp_q.push_back('{wb: 3'b000, rd: 32'h0, alu: 32'h0, dir: 5'd0});
        #1;
        check("jump_pc_src", 32'(pc_src), 32'h1);
        check("jump_pc_target", pc_target, 32'h80);
        step();
        in_valid = 1'b0;
        #1;
        check("bubble_jump_pc_src", 32'(pc_src), 32'h0);
        step();
        clear_inputs();

        // Load that never gets acknowledged
        issue(3'b010, 3'b011, 32'h200, 32'h0, 5'd9);
        exp_q.push_back('{wb: 3'b010, rd: 32'h0, alu: 32'h200, dir: 5'd9});
        n = 0;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (stall) n++;
            if (c >= 1 && bus.mem_req !== 1'b1) check("timeout_req_held", 32'(bus.mem_req), 32'h1);
            if (c == 16) check("timeout_pc_src", 32'(pc_src), 32'h0);
            step();
        end
        clear_inputs();
        check("timeout_stall_cycles", 32'(n), 32'd16);
        check("timeout_mem_req", 32'(bus.mem_req), 32'h0);
        check("timeout_mem_err", 32'(mem_err), 32'h1);
        alu_op(3'b001, 32'h33, 5'd3);
        check("mem_err_sticky", 32'(mem_err), 32'h1);

        // Reset in the middle of an access
        issue(3'b010, 3'b001, 32'h300, 32'h0, 5'd4);
        step();
        step();
        check("mid_access_req", 32'(bus.mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("async_rst_valid_out", 32'(valid_out), 32'h0);
        check("async_rst_mem_err", 32'(mem_err), 32'h0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        alu_op(3'b001, 32'h44, 5'd6);
        step();
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
